// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: byte width, state encoding
// and the timeout used when the driver never drops ready.
package spi_pkg;

  localparam int SPI_BYTE = 8;
  localparam int BUSY_TMO = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set bit of req strictly after last_grant,
// wrapping modulo N. Purely combinational so any arbiter can reuse it.
module rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest candidate back to the nearest so the nearest wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master driver between N_REQ byte-stream requesters, holding
// the grant for a whole burst and returning each MISO byte to its owner.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GAP   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [SPI_BYTE*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            ack,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [SPI_BYTE-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        drv_start,
  output logic [SPI_BYTE-1:0]         drv_data,
  input  logic                        drv_ready,
  input  logic [SPI_BYTE-1:0]         drv_out
);

  localparam int IW = $clog2(N_REQ);

  state_t        state, state_nxt;
  logic [IW-1:0] last_grant;
  logic          last_q;
  logic          rsp_pend;
  logic [7:0]    cnt, cnt_nxt;
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic          take, ld_byte, cap, fin;

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      grant_id   <= '0;
      last_grant <= IW'(N_REQ - 1);
      last_q     <= 1'b0;
      rsp_pend   <= 1'b0;
      rsp_data   <= '0;
      drv_data   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rsp_pend <= cap;
      if (take) grant_id <= pick_idx;
      if (ld_byte) begin
        drv_data <= req_data[SPI_BYTE*int'(grant_id) +: SPI_BYTE];
        last_q   <= req_last[grant_id];
      end
      if (cap) rsp_data <= drv_out;
      if (fin && last_q) last_grant <= grant_id;
    end
  end

  // cnt doubles as the ready-drop timeout and the inter-byte gap timer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ack       = '0;
    drv_start = 1'b0;
    take      = 1'b0;
    ld_byte   = 1'b0;
    cap       = 1'b0;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          take      = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req[grant_id] && drv_ready) begin
          ack[grant_id] = 1'b1;
          ld_byte       = 1'b1;
          state_nxt     = S_START;
        end
      end
      S_START: begin
        drv_start = 1'b1;
        cnt_nxt   = 8'(BUSY_TMO);
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!drv_ready || cnt == 8'd1) state_nxt = S_WAIT_DONE;
        else cnt_nxt = cnt - 8'd1;
      end
      S_WAIT_DONE: begin
        // rsp_valid occupies one extra cycle here before the gap starts.
        if (rsp_pend) begin
          fin = 1'b1;
          if (GAP > 0) begin
            cnt_nxt   = 8'(GAP);
            state_nxt = S_GAP;
          end else begin
            state_nxt = last_q ? S_IDLE : S_LOAD;
          end
        end else if (drv_ready) begin
          cap = 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == 8'd1) state_nxt = last_q ? S_IDLE : S_LOAD;
        else cnt_nxt = cnt - 8'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pend) rsp_valid[grant_id] = 1'b1;
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Randomized bench for spi_master_arbiter: per-requester byte queues, a
// round-robin ownership model and a simple SPI driver model that echoes ~byte.
module tb_spi_master_arbiter;

  localparam int N      = 3;
  localparam int TB_GAP = 5;
  localparam int IW     = $clog2(N);
  localparam int QD     = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   ack, rsp_valid;
  logic [7:0]     rsp_data, drv_data, drv_out;
  logic [IW-1:0]  grant_id;
  logic           busy, drv_start, drv_ready;

  always #5 clk = ~clk;

  spi_master_arbiter #(.N_REQ(N), .GAP(TB_GAP)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_last  (req_last),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .drv_start (drv_start),
    .drv_data  (drv_data),
    .drv_ready (drv_ready),
    .drv_out   (drv_out)
  );

  // Bench model state
  logic [8:0] rq [N][QD];
  int   rq_head [N];
  int   rq_tail [N];
  int   stall_cnt [N];
  int   rsp_cnt [N];
  logic [9:0] exp_q [$];
  int   order_q [$];
  int   n_chk = 0, n_pass = 0, cyc = 0;
  int   cur_owner = -1, last_owner = N - 1, burst_pos = 0;
  int   rise_cyc = 0, start_cyc = 0, drv_cnt = 0, drv_lat_max = 6;
  bit   rise_intra = 0, gap_chk = 1, prev_ready = 1, stall_arm = 0;
  bit   drv_stuck = 0, start_seen = 0, last_sent_last = 0;
  logic [7:0] last_sent = '0, drv_hold = '0;

  // Driver model: drops ready on start, raises it after a random latency
  // with data_out = ~data_in. In stuck mode it never drops ready.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      drv_ready <= 1'b1;
      drv_out   <= '0;
      drv_cnt   <= 0;
    end else if (drv_stuck) begin
      drv_ready <= 1'b1;
      drv_out   <= 8'h99;
    end else if (drv_ready && drv_start) begin
      drv_ready <= 1'b0;
      drv_hold  <= drv_data;
      drv_out   <= 8'($urandom);
      drv_cnt   <= $urandom_range(drv_lat_max, 1);
    end else if (!drv_ready) begin
      if (drv_cnt <= 1) begin
        drv_ready <= 1'b1;
        drv_out   <= ~drv_hold;
      end else begin
        drv_cnt <= drv_cnt - 1;
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      rq_head[i] = 0; rq_tail[i] = 0; stall_cnt[i] = 0; rsp_cnt[i] = 0;
    end
    order_q.delete();
  endtask

  task automatic add_byte(input int r, input logic [7:0] b, input bit last);
    rq[r][rq_tail[r]] = {last, b};
    rq_tail[r]++;
  endtask

  task automatic add_burst(input int r, input int len);
    for (int k = 0; k < len; k++) add_byte(r, 8'($urandom), k == len - 1);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (rq_head[i] < rq_tail[i]) return 0;
    return 1;
  endfunction

  // Next owner: first requester with pending bytes after the previous owner.
  function automatic int rr_next();
    for (int k = 1; k <= N; k++) begin
      int j = (last_owner + k) % N;
      if (rq_head[j] < rq_tail[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      bit has = rq_head[i] < rq_tail[i];
      logic [8:0] it = has ? rq[i][rq_head[i]] : 9'($urandom);
      req[i] = has && stall_cnt[i] == 0;
      req_data[8*i +: 8] = it[7:0];
      req_last[i] = has && it[8];
      if (stall_cnt[i] > 0) stall_cnt[i]--;
    end
  endtask

  task automatic observe();
    int i, exp_o;
    logic [8:0] item;
    logic [9:0] e;
    bit lat_ok;
    if (drv_ready && !prev_ready) begin
      rise_cyc   = cyc;
      rise_intra = !last_sent_last;
    end
    prev_ready = drv_ready;
    if (ack != '0) begin
      i = 0;
      for (int k = N - 1; k >= 0; k--) if (ack[k]) i = k;
      n_chk++;
      if ($countones(ack) != 1) $display("FAIL ack_onehot ack=%b required one-hot", ack);
      else n_pass++;
      exp_o = (cur_owner >= 0) ? cur_owner : rr_next();
      n_chk++;
      if (i != exp_o || int'(grant_id) != exp_o)
        $display("FAIL ack_owner ack_idx=%0d grant_id=%0d required %0d", i, grant_id, exp_o);
      else n_pass++;
      if (rq_head[i] < rq_tail[i]) begin
        item = rq[i][rq_head[i]];
        rq_head[i]++;
        if (cur_owner < 0) begin order_q.push_back(i); burst_pos = 0; end
        else burst_pos++;
        exp_q.push_back({2'(i), drv_stuck ? 8'h99 : ~item[7:0]});
        last_sent = item[7:0];
        last_sent_last = item[8];
        cur_owner = item[8] ? -1 : i;
        if (item[8]) last_owner = i;
        if (stall_arm && i == 0 && burst_pos == 0 && !item[8]) begin
          stall_cnt[0] = 10;
          stall_arm = 0;
        end
      end
    end
    if (stall_cnt[0] > 0) begin
      n_chk++;
      if (!busy || grant_id != 0) $display("FAIL stall_hold busy=%0b grant_id=%0d required 1/0", busy, grant_id);
      else n_pass++;
    end
    if (drv_start) begin
      start_cyc  = cyc;
      start_seen = 1;
      n_chk++;
      if (drv_data !== last_sent) $display("FAIL drv_data got=%h required %h", drv_data, last_sent);
      else n_pass++;
      if (rise_intra && gap_chk && !drv_stuck) begin
        n_chk++;
        if (cyc - rise_cyc != TB_GAP + 3)
          $display("FAIL byte_gap got=%0d required %0d", cyc - rise_cyc, TB_GAP + 3);
        else n_pass++;
      end
      rise_intra = 0;
    end
    if (rsp_valid != '0) begin
      i = 0;
      for (int k = N - 1; k >= 0; k--) if (rsp_valid[k]) i = k;
      n_chk++;
      if ($countones(rsp_valid) != 1 || exp_q.size() == 0)
        $display("FAIL rsp_valid got=%b pending=%0d required one-hot with a pending byte", rsp_valid, exp_q.size());
      else begin
        n_pass++;
        e = exp_q.pop_front();
        rsp_cnt[i]++;
        n_chk++;
        if (i != int'(e[9:8]) || rsp_data !== e[7:0])
          $display("FAIL rsp_data idx=%0d data=%h required idx=%0d data=%h", i, rsp_data, e[9:8], e[7:0]);
        else n_pass++;
        lat_ok = drv_stuck ? (cyc == start_cyc + 6) : (cyc == rise_cyc + 1);
        n_chk++;
        if (!lat_ok)
          $display("FAIL rsp_latency cyc=%0d start=%0d rise=%0d stuck=%0b", cyc, start_cyc, rise_cyc, drv_stuck);
        else n_pass++;
      end
    end
  endtask

  task automatic run(input int budget, input bit stop_flight);
    int n = 0;
    bit done = 0;
    start_seen = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      drive_inputs();
      @(negedge clk);
      observe();
      n++;
      if (stop_flight) done = start_seen && !drv_ready && (cyc - start_cyc >= 3);
      else done = all_empty() && cur_owner < 0 && exp_q.size() == 0 && !busy;
      if (!done && n >= budget) begin
        n_chk++;
        $display("FAIL run_timeout budget=%0d cycles exhausted", budget);
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    clear_model();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({ack, rsp_valid, rsp_data, grant_id, busy, drv_start, drv_data} !== '0)
      $display("FAIL reset_outputs got=%h required 0", {ack, rsp_valid, rsp_data, grant_id, busy, drv_start, drv_data});
    else n_pass++;
    #1 rst = 1'b1;
  endtask

  task automatic test_contention();
    int exp_ord [4] = '{0, 1, 0, 1};
    clear_model();
    add_burst(0, 1); add_burst(0, 1); add_burst(1, 1); add_burst(1, 1);
    run(2000, 0);
    n_chk++;
    if (order_q.size() != 4) $display("FAIL contention_count got=%0d required 4", order_q.size());
    else begin
      n_pass++;
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (order_q[k] != exp_ord[k]) $display("FAIL contention_order[%0d] got=%0d required %0d", k, order_q[k], exp_ord[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single_burst();
    clear_model();
    add_byte(0, 8'hA5, 0);
    add_byte(0, 8'h3C, 1);
    run(2000, 0);
    n_chk++;
    if (rsp_cnt[0] != 2 || busy !== 1'b0) $display("FAIL single_burst rsp=%0d busy=%0b required 2/0", rsp_cnt[0], busy);
    else n_pass++;
  endtask

  task automatic test_burst_hold();
    clear_model();
    add_burst(1, 1);
    run(2000, 0);
    clear_model();
    add_burst(0, 3); add_burst(1, 1);
    run(2000, 0);
    n_chk++;
    if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 1)
      $display("FAIL burst_hold_order size=%0d required 0 then 1", order_q.size());
    else n_pass++;
  endtask

  task automatic test_gap();
    clear_model();
    drv_lat_max = 6;
    add_burst(2, 4);
    run(2000, 0);
  endtask

  task automatic test_owner_stall();
    clear_model();
    add_burst(1, 1);
    run(2000, 0);
    clear_model();
    gap_chk = 0;
    stall_arm = 1;
    add_burst(0, 3); add_burst(1, 2);
    run(3000, 0);
    gap_chk = 1;
    n_chk++;
    if (rsp_cnt[0] != 3 || rsp_cnt[1] != 2 || stall_arm)
      $display("FAIL stall_resume rsp0=%0d rsp1=%0d armed=%0b required 3/2/0", rsp_cnt[0], rsp_cnt[1], stall_arm);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_model();
    drv_stuck = 1;
    add_burst(2, 2);
    run(2000, 0);
    drv_stuck = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      clear_model();
      drv_lat_max = $urandom_range(6, 1);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(1, 0) == 1) add_burst(i, $urandom_range(4, 1));
        if ($urandom_range(3, 0) == 0) add_burst(i, $urandom_range(3, 1));
      end
      if (all_empty()) add_burst($urandom_range(N - 1, 0), 2);
      run(4000, 0);
    end
    drv_lat_max = 6;
  endtask

  task automatic test_reset_mid();
    clear_model();
    add_burst(0, 1);
    run(2000, 0);
    clear_model();
    drv_lat_max = 12;
    drv_hold = 8'h00;
    add_burst(1, 2);
    run(2000, 1);
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if ({ack, rsp_valid, rsp_data, grant_id, busy, drv_start, drv_data} !== '0)
      $display("FAIL reset_mid_outputs got=%h required 0", {ack, rsp_valid, rsp_data, grant_id, busy, drv_start, drv_data});
    else n_pass++;
    clear_model();
    exp_q.delete();
    req = '0; req_last = '0;
    cur_owner = -1; last_owner = N - 1; prev_ready = 1; rise_intra = 0; last_sent_last = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (rsp_valid !== '0 || busy !== 1'b0) $display("FAIL reset_hold rsp_valid=%b busy=%0b required 0", rsp_valid, busy);
    else n_pass++;
    #1 rst = 1'b1;
    drv_lat_max = 6;
    add_burst(1, 1); add_burst(0, 1);
    run(2000, 0);
    n_chk++;
    if (order_q.size() == 0 || order_q[0] != 0) $display("FAIL reset_first_grant size=%0d required first owner 0", order_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_burst();
    test_burst_hold();
    test_gap();
    test_owner_stall();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter that shares one `spi_master_driver` between `N_REQ` byte-stream requesters. It holds a grant for a whole multi-byte burst, sequences the driver's start/ready handshake byte by byte and enforces a programmable idle gap between bytes. It returns each received MISO byte to the owning requester. It sits between processor-unit SPI clients and the single SPI master driver instance on the board interface.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `GAP`, default 2: idle clk cycles between driver `ready` rising and the next `start_transaction`, 0..255.
- `clk` in 1: system clock, all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-low (0 = reset).
- `req` in N_REQ: requester i has a byte to send; held until `ack[i]`.
- `req_data` in 8*N_REQ: byte of requester i at bits [8i+7:8i].
- `req_last` in N_REQ: byte is the final byte of requester i's burst.
- `ack` out N_REQ: one-cycle pulse; requester i's byte was handed to the driver.
- `rsp_valid` out N_REQ: one-cycle pulse; MISO byte for requester i on `rsp_data`.
- `rsp_data` out 8: received byte, valid only with a `rsp_valid` bit.
- `grant_id` out $clog2(N_REQ): current owner, valid while `busy`.
- `busy` out 1: a burst is in progress.
- `drv_start` out 1: to driver `start_transaction`.
- `drv_data` out 8: to driver `data_in`, stable from `drv_start` until `drv_ready` returns high.
- `drv_ready` in 1: driver idle/done level; `data_out` valid while high after a transfer.
- `drv_out` in 8: driver `data_out`.

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any `req` is high, pick the first requester at or after `last_grant+1` (mod N_REQ) and go to LOAD. Set `grant_id` and `busy`=1.
- LOAD: wait for `req[grant_id]` and `drv_ready`. Latch the byte into `drv_data` and `req_last` into `last_q`. Pulse `ack[grant_id]`, then go to START.
- START: drive `drv_start`=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for `drv_ready`=0. If it is still high after 4 cycles, treat the transfer as done (driver did not drop `ready`) and go to WAIT_DONE evaluation.
- WAIT_DONE: on `drv_ready`=1, capture `drv_out` into `rsp_data` and pulse `rsp_valid[grant_id]` the next cycle. Then:
  - `last_q`=1: update `last_grant`=`grant_id` and go to IDLE (or GAP when GAP>0). `busy` drops when IDLE is re-entered.
  - `last_q`=0: go to GAP, then LOAD for the same owner.
- GAP: count GAP cycles (skipped when GAP=0), then go to LOAD or IDLE as selected above.
- Mid-burst, other requesters are ignored; the owner may stall by holding `req` low in LOAD, and the grant is kept.
- Reset: state IDLE, `last_grant`=N_REQ-1 (so requester 0 wins first). All outputs 0: `ack`, `rsp_valid`, `rsp_data`, `grant_id`, `busy`, `drv_start`, `drv_data`. Asserting `rst` mid-transfer abandons the burst immediately with no `rsp_valid`.
- Only `req` and `req_last` are sampled; `req_data` of non-owners is don't-care.

## Timing
- IDLE to LOAD: 1 cycle. LOAD to START (`ack` cycle): 1 cycle if `req` and `drv_ready` are high.
- `drv_start` is high in the cycle after `ack`.
- `rsp_valid` comes 1 cycle after `drv_ready` rises.
- Byte-to-byte spacing within a burst: driver transfer + GAP + 3 cycles.
- Simultaneous requests in IDLE: exactly one grant, by round-robin order. Ties never produce two `ack` bits.
- Wrap-around: after `last_grant`=N_REQ-1, the search starts at 0.
- `ack` and `rsp_valid` are one-hot or zero in every cycle.

## Structure
- Shared package `spi_pkg` holds:
  - the state encoding constants (IDLE..GAP);
  - the WAIT_BUSY timeout constant (4);
  - the `SPI_BYTE` width (8).
- Sub-module `rr_pick` (combinational): inputs `req` vector and `last_grant`; outputs `found` and `idx`. It is reusable by other shared-resource arbiters.
- The FSM, gap counter and byte registers stay in the top module. Expected RTL size is about 200 lines.

## Test plan
- Single burst: req0 sends 0xA5, 0x3C with last on the second byte; driver model echoes inverted bytes. Expect `ack[0]` twice, `rsp_valid[0]` with 0x5A then 0xC3, then `busy`=0.
- Contention: req0 and req1 both high from reset, one-byte bursts. Expect grant order 0,1,0,1 over 4 bursts and never two `ack` bits in one cycle.
- Burst hold: req0 runs a 3-byte burst while req1 is asserted throughout. Expect all 3 req0 bytes before any `ack[1]`.
- Gap: GAP=5. Measure the cycle from `drv_ready` rise to the next `drv_start`; expect exactly 5+3.
- Owner stall: req0 drops `req` for 10 cycles mid-burst while req1 is high. Expect `grant_id` to stay 0, no `ack[1]`, and the burst to resume.
- Reset mid-transfer: assert `rst`=0 during WAIT_DONE. Expect all outputs 0 immediately, state IDLE, and first grant to 0 after release.
